bus_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single peripheral bus (LED, button and memory-mapped slaves) between the CPU data port (M0) and a secondary master (M1, DMA or debug).
It registers the winning master's request, drives one slave-side transaction at a time, and returns read data and a one-cycle completion pulse.
Output ctrl identifies the current bus owner and is the bus-ownership signal probed in the logic analyzer.

---
 rtl/bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral bus (M0 = CPU data, M1 = DMA/debug).
// Optional slave timeout/abort is built only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          m1_err,
    output logic          s_req,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic          ctrl,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          s_req_q, s_req_d;
    logic          s_we_q, s_we_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic          m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
    logic          ctrl_q, ctrl_d;
    logic          last_q, last_d;
    logic          win;
    logic          finish;
    logic [DW-1:0] fin_data;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        ctrl_d     = ctrl_q;
        last_d     = last_q;
        win        = 1'b0;
        finish     = 1'b0;
        fin_data   = '0;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        abort_d    = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that did not win last time goes next
                    win       = (m0_req && m1_req) ? ~last_q : m1_req;
                    ctrl_d    = win;
                    last_d    = win;
                    s_we_d    = win ? m1_we    : m0_we;
                    s_addr_d  = win ? m1_addr  : m0_addr;
                    s_wdata_d = win ? m1_wdata : m0_wdata;
                    s_req_d   = 1'b1;
                    state_d   = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    abort_d   = 1'b0;
`endif
                end
            end
            BUSY: begin
                if (s_ready) begin
                    finish   = 1'b1;
                    fin_data = s_we_q ? '0 : s_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (finish) begin
            s_req_d = 1'b0;
            state_d = DONE;
            if (ctrl_q) begin
                m1_rdata_d = fin_data;
                m1_ready_d = 1'b1;
            end else begin
                m0_rdata_d = fin_data;
                m0_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            ctrl_q     <= 1'b0;
            last_q     <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            ctrl_q     <= ctrl_d;
            last_q     <= last_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign ctrl     = ctrl_q;
    assign busy     = (state_q != IDLE);

    // Error is only meaningful alongside the ready pulse, so it is qualified by it
`ifdef BUS_ARB_TIMEOUT_EN
    assign m0_err = m0_ready_q & abort_q;
    assign m1_err = m1_ready_q & abort_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized two-master traffic
// scored against a transaction-level round-robin model.
module tb_bus_arbiter;
    localparam int TMO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int WLAT = 3;
`else
    localparam int WLAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic        s_req, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        ctrl, busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_rd[2];

    // random-phase model state
    bit          pend[2];
    bit          we_v[2];
    logic [31:0] ad_v[2], wd_v[2];
    int          gap[2];
    int          ph, win, lastw, lat, bc, w;
    logic [31:0] exp_d, rd;

    bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .ctrl(ctrl), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0;
    endtask

    // Waits for the grant, checks the slave side, answers after lat extra cycles,
    // and returns at the negedge where the ready pulse is visible.
    task automatic serve(input int m, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input logic [31:0] rdv,
                         output int waited);
        logic [31:0] e;
        waited = 0;
        cyc();
        while (!s_req && waited < 20) begin
            waited++;
            cyc();
        end
        if (!s_req) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        chk("grant_ctrl", ctrl, m);
        chk("grant_we", s_we, we);
        chk("grant_addr", s_addr, addr);
        chk("grant_wdata", s_wdata, wd);
        chk("grant_busy", busy, 1);
        for (int k = 0; k < lat; k++) begin
            s_ready = 0;
            cyc();
            chk("hold_req", s_req, 1);
            chk("hold_fields", {s_we, s_addr, s_wdata}, {we, addr, wd});
        end
        s_ready = 1; s_rdata = rdv;
        cyc();
        s_ready = 0;
        e = we ? 32'h0 : rdv;
        chk("done_ready", {m1_ready, m0_ready}, (m == 1) ? 2'b10 : 2'b01);
        chk("done_rdata", (m == 1) ? m1_rdata : m0_rdata, e);
        chk("other_rdata", (m == 1) ? m0_rdata : m1_rdata, exp_rd[1-m]);
        chk("done_err", {m1_err, m0_err}, 0);
        chk("done_sreq", s_req, 0);
        exp_rd[m] = e;
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0;
        cyc();
        chk("rst_sreq", s_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_ready", {m1_ready, m0_ready, m1_err, m0_err}, 0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
        chk("rst_sbus", {s_we, s_addr, s_wdata}, 0);
        rst_n = 1'b1;

        // single read, minimum latency
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        serve(0, 0, 32'h10, 32'h0, 0, 32'hA5, w);
        chk("min_lat_wait", w, 0);
        m0_req = 0;
        cyc();
        chk("min_lat_idle", {busy, m0_ready}, 0);

        // tie after reset: M0 first, then strict alternation while both keep requesting
        do_reset();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
        serve(0, 0, 32'h100, 0, 0, 32'h11, w); chk("tie1_wait", w, 0);
        serve(1, 0, 32'h200, 0, 0, 32'h22, w); chk("tie2_wait", w, 1);
        serve(0, 0, 32'h100, 0, 1, 32'h33, w); chk("tie3_wait", w, 1);
        serve(1, 0, 32'h200, 0, 2, 32'h44, w); chk("tie4_wait", w, 1);
        m0_req = 0; m1_req = 0;
        cyc();

        // M1 write with a slow slave
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h0F;
        serve(1, 1, 32'h20, 32'h0F, WLAT, 32'hDEAD, w);
        m1_req = 0; m1_we = 0;
        cyc();
        chk("wr_no_repeat", {m1_ready, m0_ready}, 0);

        // reset in the middle of an M1 transaction
        m1_req = 1; m1_addr = 32'h40;
        cyc();
        chk("mid_sreq", {s_req, ctrl}, 2'b11);
        rst_n = 0; m1_req = 0;
        cyc();
        chk("mid_rst", {s_req, busy, ctrl}, 0);
        chk("mid_ready", {m1_ready, m0_ready}, 0);
        rst_n = 1; exp_rd[0] = 0; exp_rd[1] = 0;
        cyc();
        chk("mid_ready2", {m1_ready, m0_ready}, 0);
        m0_req = 1; m0_addr = 32'h50;
        serve(0, 0, 32'h50, 0, 0, 32'h5A, w);
        chk("mid_after_wait", w, 0);
        m0_req = 0;
        cyc();

        // slave never answers
        m0_req = 1; m0_addr = 32'h60;
        cyc();
`ifdef BUS_ARB_TIMEOUT_EN
        w = 0;
        while (s_req && w < 20) begin
            w++;
            cyc();
        end
        chk("tmo_busy_cycles", w, TMO);
        chk("tmo_ready", {m1_ready, m0_ready}, 2'b01);
        chk("tmo_err", {m1_err, m0_err}, 2'b01);
        chk("tmo_rdata", m0_rdata, 0);
        m0_req = 0;
        cyc();
        chk("tmo_pulse", {m0_ready, m0_err}, 0);
`else
        w = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!s_req || m0_ready || m0_err) w++;
            cyc();
        end
        chk("hang_violations", w, 0);
        m0_req = 0;
`endif

        // randomized traffic against the transaction model
        do_reset();
        pend = '{0, 0}; gap = '{0, 0}; ph = 0; lastw = 1; win = 0; lat = 0; bc = 0;
        for (int c = 0; c < 700; c++) begin
            cyc();
            if (ph == 2) begin
                chk("rnd_ready", {m1_ready, m0_ready}, (win == 1) ? 2'b10 : 2'b01);
                chk("rnd_rdata", (win == 1) ? m1_rdata : m0_rdata, exp_d);
                chk("rnd_other", (win == 1) ? m0_rdata : m1_rdata, exp_rd[1-win]);
                chk("rnd_err", {m1_err, m0_err}, 0);
                chk("rnd_sreq_off", s_req, 0);
                exp_rd[win] = exp_d;
                pend[win] = 0;
                gap[win] = $urandom_range(2, 0);
                s_ready = 0;
                ph = 0;
            end else begin
                chk("rnd_no_ready", {m1_ready, m0_ready}, 0);
                if (ph == 0 && s_req) begin
                    if (!pend[0] && !pend[1]) chk("rnd_spurious", 0, 1);
                    win = (pend[0] && pend[1]) ? 1 - lastw : (pend[1] ? 1 : 0);
                    lastw = win;
                    chk("rnd_ctrl", ctrl, win);
                    chk("rnd_fields", {s_we, s_addr, s_wdata}, {we_v[win], ad_v[win], wd_v[win]});
                    lat = $urandom_range(TMO - 1, 0);
                    bc = 0;
                    ph = 1;
                end else if (ph == 1) begin
                    chk("rnd_hold", {s_req, s_we, s_addr, s_wdata},
                        {1'b1, we_v[win], ad_v[win], wd_v[win]});
                end
                if (ph == 1) begin
                    if (bc == lat) begin
                        rd = $urandom;
                        s_ready = 1; s_rdata = rd;
                        exp_d = we_v[win] ? 32'h0 : rd;
                        ph = 2;
                    end else begin
                        s_ready = 0;
                        s_rdata = $urandom;
                        bc++;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if (c < 600 && $urandom_range(1, 0) == 1) begin
                        pend[i] = 1; we_v[i] = $urandom_range(1, 0) == 1;
                        ad_v[i] = $urandom; wd_v[i] = $urandom;
                    end
                end
            end
            m0_req = pend[0]; m0_we = we_v[0]; m0_addr = ad_v[0]; m0_wdata = wd_v[0];
            m1_req = pend[1]; m1_we = we_v[1]; m1_addr = ad_v[1]; m1_wdata = wd_v[1];
        end
        chk("rnd_drained", {pend[1], pend[0], ph[1:0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
